rf_param_sb: RTL and testbench

- Parametrised next-generation register file for the CPU decode/writeback path: configurable data width and register count, two combinational read ports, one write port.
- Adds an optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard used by decode for hazard detection.
- Adds a sticky synthesizable error flag. The previous block drove its error output constantly low.

---
 rtl/rf_param_sb.sv | 104 ++++++++++
 tb/tb_rf_param_sb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_param_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero r0, busy scoreboard, sticky error.

module rf_param_sb_cell #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              set,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q,
   output logic              busy
);
   // A same-edge reservation beats the clearing write.
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         busy <= 1'b0;
      end else begin
         if (we)
            q <= wdata;
         if (set)
            busy <= 1'b1;
         else if (we)
            busy <= 1'b0;
      end
   end
endmodule

module rf_param_sb #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] read1regsel,
   input  logic [ADDR_W-1:0] read2regsel,
   input  logic [ADDR_W-1:0] writeregsel,
   input  logic [DATA_W-1:0] writedata,
   input  logic              write,
   input  logic [ADDR_W-1:0] resvregsel,
   input  logic              resv,
   output logic [DATA_W-1:0] read1data,
   output logic [DATA_W-1:0] read2data,
   output logic              read1busy,
   output logic              read2busy,
   output logic              err_reg
);
   localparam int            NSEL = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

   logic wr_ok, rv_ok, wr_eff, rv_eff, dbl_resv, err_ev;
   logic fwd1, fwd2;

   // Select space is padded to 2**ADDR_W; unimplemented slots read as constant 0,
   // so out-of-range reads fall out of plain indexing.
   logic [NSEL-1:0][DATA_W-1:0] q_all;
   logic [NSEL-1:0]             b_all;

   assign wr_ok  = {1'b0, writeregsel} < NREG;
   assign rv_ok  = {1'b0, resvregsel}  < NREG;
   assign wr_eff = write && wr_ok && !(ZERO_REG != 0 && writeregsel == '0);
   assign rv_eff = resv  && rv_ok && !(ZERO_REG != 0 && resvregsel  == '0);

   assign dbl_resv = rv_eff && b_all[resvregsel] && !(wr_eff && writeregsel == resvregsel);
   assign err_ev   = (write && !wr_ok) || (resv && !rv_ok) || dbl_resv;

   for (genvar i = 0; i < NSEL; i++) begin : g_reg
      if (i >= NUM_REGS || (ZERO_REG != 0 && i == 0)) begin : g_const
         assign q_all[i] = '0;
         assign b_all[i] = 1'b0;
      end else begin : g_cell
         rf_param_sb_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_eff && writeregsel == ADDR_W'(i)),
            .set   (rv_eff && resvregsel == ADDR_W'(i)),
            .wdata (writedata),
            .q     (q_all[i]),
            .busy  (b_all[i])
         );
      end
   end

   assign fwd1 = (BYPASS != 0) && wr_eff && (writeregsel == read1regsel);
   assign fwd2 = (BYPASS != 0) && wr_eff && (writeregsel == read2regsel);

   // A forwarded register is never reported busy: its value is on the bus now.
   assign read1data = fwd1 ? writedata : q_all[read1regsel];
   assign read2data = fwd2 ? writedata : q_all[read2regsel];
   assign read1busy = fwd1 ? 1'b0 : b_all[read1regsel];
   assign read2busy = fwd2 ? 1'b0 : b_all[read2regsel];

   always_ff @(posedge clk) begin
      if (rst)
         err_reg <= 1'b0;
      else if (err_ev)
         err_reg <= 1'b1;
   end
endmodule

// File: tb/tb_rf_param_sb.sv
// Scoreboard bench for rf_param_sb: two configurations driven with shared
// directed + random stimulus, checked against an array-based reference model.

module tb_rf_param_sb;
   logic        clk = 1'b0;
   logic        rst, wr, rv;
   logic [2:0]  r1, r2, ws, rs;
   logic [31:0] wd;

   logic [15:0] a_r1d, a_r2d;
   logic        a_r1b, a_r2b, a_err;
   logic [31:0] b_r1d, b_r2d;
   logic        b_r1b, b_r2b, b_err;

   always #5 clk = ~clk;

   // A: 16b, 6 regs, bypass, zero reg.  B: 32b, 8 regs, no bypass, no zero reg.
   rf_param_sb #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2), .writeregsel(ws),
      .writedata(wd[15:0]), .write(wr), .resvregsel(rs), .resv(rv),
      .read1data(a_r1d), .read2data(a_r2d), .read1busy(a_r1b), .read2busy(a_r2b), .err_reg(a_err));

   rf_param_sb #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2), .writeregsel(ws),
      .writedata(wd), .write(wr), .resvregsel(rs), .resv(rv),
      .read1data(b_r1d), .read2data(b_r2d), .read1busy(b_r1b), .read2busy(b_r2b), .err_reg(b_err));

   typedef struct {
      logic [31:0] d1 [2];
      logic [31:0] d2 [2];
      logic        b1 [2];
      logic        b2 [2];
      logic        er [2];
   } exp_t;

   exp_t sbq[$];

   // Reference model state, index 0 = dut_a, 1 = dut_b
   logic [31:0] m_mem  [2][8];
   logic        m_busy [2][8];
   logic        m_err  [2];
   int          nr  [2] = '{6, 8};
   bit          byp [2] = '{1'b1, 1'b0};
   bit          zr  [2] = '{1'b1, 1'b0};
   logic [31:0] msk [2] = '{32'h0000FFFF, 32'hFFFFFFFF};

   int n_chk  = 0;
   int n_pass = 0;

   function automatic bit sel_live(int d, int sel);
      return sel < nr[d] && !(zr[d] && sel == 0);
   endfunction

   function automatic bit wr_lands(int d);
      return wr && sel_live(d, int'(ws));
   endfunction

   function automatic logic [31:0] exp_data(int d, int sel);
      if (!sel_live(d, sel)) return 32'h0;
      if (byp[d] && wr_lands(d) && int'(ws) == sel) return wd & msk[d];
      return m_mem[d][sel];
   endfunction

   function automatic logic exp_busy(int d, int sel);
      if (!sel_live(d, sel)) return 1'b0;
      if (byp[d] && wr_lands(d) && int'(ws) == sel) return 1'b0;
      return m_busy[d][sel];
   endfunction

   function automatic void model_step(int d);
      int w = int'(ws);
      int v = int'(rs);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[d][i]  = 32'h0;
            m_busy[d][i] = 1'b0;
         end
         m_err[d] = 1'b0;
         return;
      end
      if (wr && w >= nr[d]) m_err[d] = 1'b1;
      if (rv && v >= nr[d]) m_err[d] = 1'b1;
      if (rv && sel_live(d, v) && m_busy[d][v] && !(wr_lands(d) && w == v)) m_err[d] = 1'b1;
      if (wr_lands(d)) begin
         m_mem[d][w]  = wd & msk[d];
         m_busy[d][w] = 1'b0;
      end
      if (rv && sel_live(d, v)) m_busy[d][v] = 1'b1;
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
   endfunction

   // Inputs change just after a rising edge; expected outputs for this cycle
   // come from the model state before the model absorbs this cycle's edge.
   task automatic cyc(bit check, bit r, int a1, int a2, bit w, int wsel,
                      logic [31:0] wdat, bit v, int rsel);
      exp_t e;
      rst = r; r1 = 3'(a1); r2 = 3'(a2);
      wr = w;  ws = 3'(wsel); wd = wdat;
      rv = v;  rs = 3'(rsel);
      if (check) begin
         for (int d = 0; d < 2; d++) begin
            e.d1[d] = exp_data(d, a1);
            e.d2[d] = exp_data(d, a2);
            e.b1[d] = exp_busy(d, a1);
            e.b2[d] = exp_busy(d, a2);
            e.er[d] = m_err[d];
         end
         sbq.push_back(e);
      end
      for (int d = 0; d < 2; d++) model_step(d);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("a_read1data", {16'h0, a_r1d}, e.d1[0]);
         chk("a_read2data", {16'h0, a_r2d}, e.d2[0]);
         chk("a_read1busy", {31'h0, a_r1b}, {31'h0, e.b1[0]});
         chk("a_read2busy", {31'h0, a_r2b}, {31'h0, e.b2[0]});
         chk("a_err_reg",   {31'h0, a_err}, {31'h0, e.er[0]});
         chk("b_read1data", b_r1d, e.d1[1]);
         chk("b_read2data", b_r2d, e.d2[1]);
         chk("b_read1busy", {31'h0, b_r1b}, {31'h0, e.b1[1]});
         chk("b_read2busy", {31'h0, b_r2b}, {31'h0, e.b2[1]});
         chk("b_err_reg",   {31'h0, b_err}, {31'h0, e.er[1]});
      end
   end

   initial begin
      rst = 1'b0; wr = 1'b0; rv = 1'b0;
      r1 = '0; r2 = '0; ws = '0; rs = '0; wd = '0;
      @(posedge clk);
      #1;
      cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 0);
      for (int s = 0; s < 8; s++) cyc(1, 0, s, 7 - s, 0, 0, 32'h0, 0, 0);

      // same-cycle bypass vs. next-cycle readback
      cyc(1, 0, 5, 5, 1, 5, 32'h0000A5A5, 0, 0);
      cyc(1, 0, 5, 5, 0, 0, 32'h0, 0, 0);

      // scoreboard: reserve, clear by write, then simultaneous resv + write
      cyc(1, 0, 3, 3, 0, 0, 32'h0, 1, 3);
      cyc(1, 0, 3, 3, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 3, 3, 1, 3, 32'h00000042, 0, 0);
      cyc(1, 0, 3, 3, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 3, 3, 1, 3, 32'h00000077, 1, 3);
      cyc(1, 0, 3, 3, 0, 0, 32'h0, 0, 0);

      // register 0 write + reservation
      cyc(1, 0, 0, 0, 1, 0, 32'h0000FFFF, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);

      // full-width data
      cyc(1, 0, 2, 2, 1, 2, 32'hDEADBEEF, 0, 0);
      cyc(1, 0, 2, 2, 0, 0, 32'h0, 0, 0);

      // out-of-range write (select 7 is invalid only for the 6-register file)
      cyc(1, 0, 7, 1, 1, 7, 32'h00001111, 0, 0);
      cyc(1, 0, 7, 1, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 7, 5, 0, 0, 32'h0, 0, 0);

      // double reservation after a clean reset; sticky until reset
      cyc(1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 2, 2, 0, 0, 32'h0, 1, 2);
      cyc(1, 0, 2, 2, 0, 0, 32'h0, 1, 2);
      cyc(1, 0, 2, 2, 1, 2, 32'h00000009, 0, 0);
      cyc(1, 0, 2, 2, 0, 0, 32'h0, 0, 0);

      // reset dominates a same-cycle write + reservation
      cyc(1, 0, 1, 1, 1, 1, 32'h00001111, 0, 0);
      cyc(1, 1, 1, 1, 1, 1, 32'h00001234, 1, 1);
      cyc(1, 0, 1, 1, 0, 0, 32'h0, 0, 0);

      for (int n = 0; n < 3000; n++)
         cyc(1, $urandom_range(0, 59) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 7));

      repeat (2) @(negedge clk);
      n_chk++;
      if (sbq.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
